synth_tb_run_controller: RTL and testbench
==========================================

# synth_tb_run_controller

Run controller that sits directly upstream and downstream of the synthesizable CV32E40P test subsystem. It sequences the core's reset and `fetch_enable` after a start request, counts run cycles and ALU activity, and watches the subsystem's pass/fail/exit outputs. It latches a sticky result, including an optional watchdog timeout, for FPGA or emulation harnesses.

## Interface
Parameters:
- `BOOT_DELAY`, default 16: cycles between core reset release and `fetch_enable_o` assertion. 0 means no boot wait.
- `WDOG_CYCLES`, default 1000000: watchdog limit in RUN cycles. Must be ≥ 1.
- `CNT_WIDTH`, default 32: width of the run and activity counters.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: start request. Sampled only in IDLE or DONE.
- `core_rst_no` out 1: active-low reset to the subsystem's `rst_ni`.
- `fetch_enable_o` out 1: drives the subsystem's `fetch_enable_i`.
- `tests_passed_i`, `tests_failed_i`, `exit_valid_i` in 1 each: status from the subsystem.
- `exit_value_i` in 32: exit value from the subsystem.
- `alu_en_ex_i` in 1: ALU-enable in EX stage, from the subsystem.
- `done_o`, `pass_o`, `fail_o`, `timeout_o` out 1 each: sticky result flags.
- `exit_code_o` out 32: latched exit code.
- `cycle_count_o` out `CNT_WIDTH`: number of RUN cycles.
- `alu_active_count_o` out `CNT_WIDTH`: number of RUN cycles with `alu_en_ex_i` high.
- `state_o` out 3: FSM state encoding.

## Operation
States and encodings:
- IDLE = 0: `core_rst_no` = 0, `fetch_enable_o` = 0.
- RESET_CORE = 1: `core_rst_no` = 0. Held for exactly 4 cycles, then go to BOOT_WAIT, or directly to RUN if `BOOT_DELAY` = 0.
- BOOT_WAIT = 2: `core_rst_no` = 1, `fetch_enable_o` = 0. Held `BOOT_DELAY` cycles, then go to RUN.
- RUN = 3: `core_rst_no` = 1, `fetch_enable_o` = 1.
- DONE = 4: `core_rst_no` = 1, so memory and state stay observable. `fetch_enable_o` = 0.

Start behaviour:
- `start_i` in IDLE or DONE moves the FSM to RESET_CORE.
- The same edge clears all result flags, `exit_code_o` and both counters.
- `start_i` in any other state is ignored.

RUN behaviour:
- `cycle_count_o` increments every RUN cycle, including the terminating cycle.
- `alu_active_count_o` increments in each RUN cycle where `alu_en_ex_i` = 1.
- Both counters saturate at all-ones and do not wrap.

Termination in RUN, highest priority first; all cases go to DONE:
1. `exit_valid_i`: `exit_code_o` = `exit_value_i`; `pass_o` = (`exit_value_i` == 0); `fail_o` = !`pass_o`.
2. `tests_failed_i`: `fail_o` = 1, `exit_code_o` = 1.
3. `tests_passed_i`: `pass_o` = 1, `exit_code_o` = 0.
4. Watchdog: `cycle_count_o` == `WDOG_CYCLES`-1 with no other event in that cycle gives `timeout_o` = 1, `fail_o` = 1, `exit_code_o` = 32'hDEAD_0001.

Other rules:
- Subsystem status inputs are ignored outside RUN.
- DONE is sticky until the next `start_i` or `rst_i`.

## Timing
Reset values (on `rst_i`):
- State IDLE.
- `core_rst_no` = 0, `fetch_enable_o` = 0.
- All flags = 0, `exit_code_o` = 0, counters = 0, `state_o` = 0.

Timing rules:
- All outputs are registered. No combinational input-to-output path.
- `start_i` high at edge 0 gives: state RESET_CORE at cycle 1; `core_rst_no` low for cycles 1–4; BOOT_WAIT for cycles 5..4+`BOOT_DELAY`; `fetch_enable_o` high from cycle 5+`BOOT_DELAY`.
- A terminating event sampled at edge N gives `done_o` and the result flags at N+1, with `fetch_enable_o` = 0 at N+1.
- Simultaneous events resolve by the termination priority list above.
- `start_i` in the same cycle as DONE entry is ignored, because the FSM is not yet in DONE.
- `rst_i` asserted mid-run returns immediately to the reset values, independent of the clock.

## Configuration
- `SYNTH_TB_WATCHDOG_EN` defined: watchdog active as described.
- Not defined: no watchdog logic is built, `timeout_o` is tied to 0, and RUN ends only on a subsystem event.

## Test plan
- `BOOT_DELAY`=16; `start_i` pulse at cycle 0 → `core_rst_no` low for cycles 1–4, `fetch_enable_o` rises at cycle 21, `state_o` = 3.
- In RUN, `exit_valid_i`=1 with `exit_value_i`=0 after 100 RUN cycles → `done_o`=1, `pass_o`=1, `exit_code_o`=0, `cycle_count_o`=100, `fetch_enable_o`=0 one cycle later.
- `exit_valid_i` with `exit_value_i`=5 together with `tests_passed_i` in the same cycle → `fail_o`=1, `pass_o`=0, `exit_code_o`=5.
- `WDOG_CYCLES`=50 with macro defined, no events → `timeout_o`=1, `fail_o`=1, `exit_code_o`=32'hDEAD_0001, `cycle_count_o`=50. Without the macro, still in RUN after 1000 cycles.
- `alu_en_ex_i` high in 30 of 60 RUN cycles, then `tests_failed_i` → `alu_active_count_o`=30, `fail_o`=1, `exit_code_o`=1. A following `start_i` clears all results and restarts the sequence.
- `rst_i` pulsed mid-RUN → all outputs return to reset values asynchronously. A later `start_i` gives normal sequencing.

Source files
------------

// File: rtl/synth_tb_run_controller.sv
// rtl/synth_tb_run_controller.sv - reset/fetch sequencer and sticky result latch for the CV32E40P test subsystem
// Watchdog is built only when SYNTH_TB_WATCHDOG_EN is defined.
module synth_tb_run_controller #(
   parameter int unsigned BOOT_DELAY  = 16,
   parameter int unsigned WDOG_CYCLES = 1000000,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   output logic                 core_rst_no,
   output logic                 fetch_enable_o,
   input  logic                 tests_passed_i,
   input  logic                 tests_failed_i,
   input  logic                 exit_valid_i,
   input  logic [31:0]          exit_value_i,
   input  logic                 alu_en_ex_i,
   output logic                 done_o,
   output logic                 pass_o,
   output logic                 fail_o,
   output logic                 timeout_o,
   output logic [31:0]          exit_code_o,
   output logic [CNT_WIDTH-1:0] cycle_count_o,
   output logic [CNT_WIDTH-1:0] alu_active_count_o,
   output logic [2:0]           state_o
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RESET_CORE = 3'd1,
      BOOT_WAIT  = 3'd2,
      RUN        = 3'd3,
      DONE       = 3'd4
   } state_e;

   if (WDOG_CYCLES < 1) begin : g_bad_wdog_cycles
      $error("WDOG_CYCLES must be at least 1");
   end

   state_e               state_q;
   logic [31:0]          phase_q;
   logic                 core_rst_n_q, fetch_en_q, done_q, pass_q, fail_q;
   logic [31:0]          exit_code_q;
   logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d, alu_cnt_q, alu_cnt_d;
   logic                 run_end;

`ifdef SYNTH_TB_WATCHDOG_EN
   localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(WDOG_CYCLES - 1);
   logic timeout_q;
   logic wdog_hit;
   assign wdog_hit  = (cycle_cnt_q == WDOG_LAST);
   assign run_end   = exit_valid_i | tests_failed_i | tests_passed_i | wdog_hit;
   assign timeout_o = timeout_q;
`else
   assign run_end   = exit_valid_i | tests_failed_i | tests_passed_i;
   assign timeout_o = 1'b0;
`endif

   // Counters saturate at all-ones rather than wrapping.
   always_comb begin
      cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_WIDTH'(1);
      alu_cnt_d   = alu_cnt_q;
      if (alu_en_ex_i && !(&alu_cnt_q)) begin
         alu_cnt_d = alu_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         phase_q      <= 32'd0;
         core_rst_n_q <= 1'b0;
         fetch_en_q   <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         exit_code_q  <= 32'd0;
         cycle_cnt_q  <= '0;
         alu_cnt_q    <= '0;
`ifdef SYNTH_TB_WATCHDOG_EN
         timeout_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  state_q      <= RESET_CORE;
                  phase_q      <= 32'd0;
                  core_rst_n_q <= 1'b0;
                  fetch_en_q   <= 1'b0;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  fail_q       <= 1'b0;
                  exit_code_q  <= 32'd0;
                  cycle_cnt_q  <= '0;
                  alu_cnt_q    <= '0;
`ifdef SYNTH_TB_WATCHDOG_EN
                  timeout_q    <= 1'b0;
`endif
               end
            end
            RESET_CORE: begin
               if (phase_q == 32'd3) begin
                  phase_q      <= 32'd0;
                  core_rst_n_q <= 1'b1;
                  if (BOOT_DELAY == 0) begin
                     state_q    <= RUN;
                     fetch_en_q <= 1'b1;
                  end else begin
                     state_q    <= BOOT_WAIT;
                  end
               end else begin
                  phase_q <= phase_q + 32'd1;
               end
            end
            BOOT_WAIT: begin
               if (phase_q == BOOT_DELAY - 1) begin
                  phase_q    <= 32'd0;
                  state_q    <= RUN;
                  fetch_en_q <= 1'b1;
               end else begin
                  phase_q <= phase_q + 32'd1;
               end
            end
            RUN: begin
               cycle_cnt_q <= cycle_cnt_d;
               alu_cnt_q   <= alu_cnt_d;
               if (run_end) begin
                  state_q    <= DONE;
                  fetch_en_q <= 1'b0;
                  done_q     <= 1'b1;
               end
               // Result priority: exit value, then failed, then passed, then watchdog.
               if (exit_valid_i) begin
                  exit_code_q <= exit_value_i;
                  pass_q      <= (exit_value_i == 32'd0);
                  fail_q      <= (exit_value_i != 32'd0);
               end else if (tests_failed_i) begin
                  fail_q      <= 1'b1;
                  exit_code_q <= 32'd1;
               end else if (tests_passed_i) begin
                  pass_q      <= 1'b1;
                  exit_code_q <= 32'd0;
`ifdef SYNTH_TB_WATCHDOG_EN
               end else if (wdog_hit) begin
                  timeout_q   <= 1'b1;
                  fail_q      <= 1'b1;
                  exit_code_q <= 32'hDEAD_0001;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign core_rst_no        = core_rst_n_q;
   assign fetch_enable_o     = fetch_en_q;
   assign done_o             = done_q;
   assign pass_o             = pass_q;
   assign fail_o             = fail_q;
   assign exit_code_o        = exit_code_q;
   assign cycle_count_o      = cycle_cnt_q;
   assign alu_active_count_o = alu_cnt_q;
   assign state_o            = state_q;

endmodule

// File: tb/tb_synth_tb_run_controller.sv
// tb/tb_synth_tb_run_controller.sv - randomized self-checking bench for synth_tb_run_controller
module tb_synth_tb_run_controller;

   localparam int BD   = 16;
   localparam int WDOG = 150;
   localparam int CW   = 8;
   localparam int SAT  = 255;

   logic          clk_i = 1'b0;
   logic          rst_i, start_i;
   logic          core_rst_no, fetch_enable_o;
   logic          tests_passed_i, tests_failed_i, exit_valid_i, alu_en_ex_i;
   logic [31:0]   exit_value_i;
   logic          done_o, pass_o, fail_o, timeout_o;
   logic [31:0]   exit_code_o;
   logic [CW-1:0] cycle_count_o, alu_active_count_o;
   logic [2:0]    state_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   synth_tb_run_controller #(
      .BOOT_DELAY (BD),
      .WDOG_CYCLES(WDOG),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .start_i           (start_i),
      .core_rst_no       (core_rst_no),
      .fetch_enable_o    (fetch_enable_o),
      .tests_passed_i    (tests_passed_i),
      .tests_failed_i    (tests_failed_i),
      .exit_valid_i      (exit_valid_i),
      .exit_value_i      (exit_value_i),
      .alu_en_ex_i       (alu_en_ex_i),
      .done_o            (done_o),
      .pass_o            (pass_o),
      .fail_o            (fail_o),
      .timeout_o         (timeout_o),
      .exit_code_o       (exit_code_o),
      .cycle_count_o     (cycle_count_o),
      .alu_active_count_o(alu_active_count_o),
      .state_o           (state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_check(input string tag);
      check({tag, "_ctl"}, 32'({state_o, core_rst_no, fetch_enable_o}), 32'd0);
      check({tag, "_flags"}, 32'({done_o, pass_o, fail_o, timeout_o}), 32'd0);
      check({tag, "_code"}, exit_code_o, 32'd0);
      check({tag, "_counts"}, 32'({cycle_count_o, alu_active_count_o}), 32'd0);
   endtask

   task automatic clear_inputs();
      tests_passed_i = 1'b0;
      tests_failed_i = 1'b0;
      exit_valid_i   = 1'b0;
      exit_value_i   = 32'd0;
      alu_en_ex_i    = 1'b0;
      start_i        = 1'b0;
   endtask

   // Pulses start and follows the boot sequence cycle by cycle, ending in the first RUN cycle.
   task automatic start_boot(input string tag);
      int  st;
      bit  rn, fe;
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int c = 1; c <= 5 + BD; c++) begin
         st = (c <= 4) ? 1 : (c <= 4 + BD) ? 2 : 3;
         rn = (c > 4);
         fe = (c > 4 + BD);
         check($sformatf("%s_ctl_c%0d", tag, c),
               32'({state_o, core_rst_no, fetch_enable_o}), 32'({3'(st), rn, fe}));
         if (c == 1) begin
            check({tag, "_cleared_flags"}, 32'({done_o, pass_o, fail_o, timeout_o}), 32'd0);
            check({tag, "_cleared_code"}, exit_code_o, 32'd0);
            check({tag, "_cleared_counts"}, 32'({cycle_count_o, alu_active_count_o}), 32'd0);
         end
         if (c < 5 + BD) begin
            tests_passed_i = 1'($urandom);
            tests_failed_i = 1'($urandom);
            exit_valid_i   = 1'($urandom);
            exit_value_i   = $urandom;
            alu_en_ex_i    = 1'($urandom);
            @(negedge clk_i);
         end
      end
   endtask

   // ev bits: [0] exit_valid, [1] tests_failed, [2] tests_passed, all raised in RUN cycle k.
   task automatic run_case(input string tag, input int k, input logic [2:0] ev,
                           input logic [31:0] val, input bit start_at_end);
      int          term, alu_n, cnt_exp, alu_exp;
      bit          wd, ends, e_pass, e_fail, a;
      logic [31:0] e_code;
      term  = k;
      wd    = 1'b0;
      alu_n = 0;
`ifdef SYNTH_TB_WATCHDOG_EN
      if (k > WDOG || (k == WDOG && ev == 3'b000)) begin
         wd   = 1'b1;
         term = WDOG;
      end
`endif
      ends   = wd || (ev != 3'b000);
      e_pass = 1'b0;
      e_fail = 1'b0;
      e_code = 32'd0;
      if (ev[0]) begin
         e_code = val;
         e_pass = (val == 32'd0);
         e_fail = (val != 32'd0);
      end else if (ev[1]) begin
         e_fail = 1'b1;
         e_code = 32'd1;
      end else if (ev[2]) begin
         e_pass = 1'b1;
      end else if (wd) begin
         e_fail = 1'b1;
         e_code = 32'hDEAD_0001;
      end
      for (int j = 1; j <= term; j++) begin
         a = 1'($urandom);
         alu_en_ex_i = a;
         if (a) alu_n++;
         exit_value_i   = (j == k) ? val : $urandom;
         exit_valid_i   = (j == k) && ev[0];
         tests_failed_i = (j == k) && ev[1];
         tests_passed_i = (j == k) && ev[2];
         start_i        = start_at_end && (j == term);
         @(negedge clk_i);
      end
      clear_inputs();
      cnt_exp = (term > SAT) ? SAT : term;
      alu_exp = (alu_n > SAT) ? SAT : alu_n;
      if (!ends) begin
         check({tag, "_ctl"}, 32'({state_o, core_rst_no, fetch_enable_o}), 32'({3'd3, 1'b1, 1'b1}));
         check({tag, "_flags"}, 32'({done_o, pass_o, fail_o, timeout_o}), 32'd0);
      end else begin
         check({tag, "_ctl"}, 32'({state_o, core_rst_no, fetch_enable_o}), 32'({3'd4, 1'b1, 1'b0}));
         check({tag, "_flags"}, 32'({done_o, pass_o, fail_o, timeout_o}),
               32'({1'b1, e_pass, e_fail, wd}));
         check({tag, "_code"}, exit_code_o, e_code);
      end
      check({tag, "_cycles"}, 32'(cycle_count_o), 32'(cnt_exp));
      check({tag, "_alu"}, 32'(alu_active_count_o), 32'(alu_exp));
      if (start_at_end && ends) begin
         @(negedge clk_i);
         check({tag, "_start_ignored_ctl"}, 32'({state_o, core_rst_no, fetch_enable_o}),
               32'({3'd4, 1'b1, 1'b0}));
         check({tag, "_start_ignored_flags"}, 32'({done_o, pass_o, fail_o, timeout_o}),
               32'({1'b1, e_pass, e_fail, wd}));
      end
   endtask

   // Raises reset between clock edges so only an asynchronous reset can clear the outputs in time.
   task automatic async_reset(input string tag);
      #2 rst_i = 1'b1;
      #1 reset_check(tag);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      logic [2:0]  ev;
      logic [31:0] val;
      int          k;
      rst_i = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk_i);
      reset_check("reset");
      rst_i = 1'b0;

      start_boot("boot1");
      run_case("exit0", 100, 3'b001, 32'd0, 1'b0);
      start_boot("boot2");
      run_case("exit5_with_passed", int'($urandom_range(10, 60)), 3'b101, 32'd5, 1'b1);
      start_boot("boot3");
      run_case("alu_then_failed", 61, 3'b010, $urandom, 1'b0);
      start_boot("boot4");
      run_case("first_cycle_passed", 1, 3'b100, 32'd0, 1'b0);
      start_boot("boot5");
      run_case("watchdog", 1000, 3'b000, 32'd0, 1'b0);
      async_reset("rst_after_watchdog");
      start_boot("boot6");
      run_case("pre_reset", 20, 3'b000, 32'd0, 1'b0);
      async_reset("rst_mid_run");
      start_boot("boot7");
      run_case("event_at_wdog_limit", WDOG, 3'b100, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         ev  = 3'($urandom_range(1, 7));
         k   = int'($urandom_range(1, 200));
         val = 32'($urandom_range(0, 3));
         start_boot($sformatf("rboot%0d", i));
         run_case($sformatf("rand%0d", i), k, ev, val, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
